// File: rtl/i_norm_pkg.sv
// rtl/i_norm_pkg.sv - shared states, classes and constants for the float-to-Q5.26 front end
package i_norm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ALIGN = 3'd2,
    SHIFT = 3'd3,
    SIGN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_SAT  = 2'd2
  } cls_t;

  localparam int          EXP_BIAS       = 127;
  localparam int          FRAC           = 26;
  // 23 mantissa bits already sit below the hidden one, so only FRAC-23 more are needed.
  localparam int          SHIFT_BIAS     = EXP_BIAS + 23 - FRAC;
  localparam logic [7:0]  EXP_SAT        = 8'd132;
  localparam logic [7:0]  EXP_ZERO_LIMIT = 8'd100;
  localparam logic [31:0] POS_SAT        = 32'h7FFF_FFFF;
  localparam logic [31:0] NEG_SAT        = 32'h8000_0000;

endpackage

// File: rtl/i_norm_barrel_shift.sv
// rtl/i_norm_barrel_shift.sv - combinational left/right aligner of the 24-bit significand
module i_norm_barrel_shift (
  input  logic [23:0]       sig,
  input  logic signed [8:0] shift,
  output logic [31:0]       mag,
  output logic              round_bit
);

  logic [31:0] ext;
  logic [8:0]  amt;

  always_comb begin
    ext       = {8'd0, sig};
    amt       = 9'd0;
    mag       = '0;
    round_bit = 1'b0;
    if (!shift[8]) begin
      mag = ext << shift;
    end else begin
      amt       = -shift;
      mag       = ext >> amt;
      // First bit shifted out; zero once the shift clears the whole significand.
      round_bit = |(ext & (32'd1 << (amt - 9'd1)));
    end
  end

endmodule

// File: rtl/i_norm_float_to_fixed.sv
// rtl/i_norm_float_to_fixed.sv - IEEE single to Q5.26 converter, start/ack FSM (option: ROUND_NEAREST_EN)
module i_norm_float_to_fixed #(
  parameter int P    = 32,
  parameter int FRAC = 26
) (
  input  logic         CLK,
  input  logic         RST_FF,
  input  logic         Begin_FSM_FF,
  input  logic [P-1:0] F,
  output logic         ACK_FF,
  output logic [P-1:0] RESULT
);
  import i_norm_pkg::*;

  localparam int SHB = EXP_BIAS + 23 - FRAC;

  state_t         state_q, state_d;
  cls_t           cls_q, cls_d;
  logic [P-1:0]   f_q, f_d;
  logic [P-1:0]   mag_q, mag_d;
  logic [P-1:0]   val_q, val_d;
  logic [P-1:0]   result_q, result_d;
  logic           ack_q, ack_d;

  logic [7:0]        exp_w;
  logic [23:0]       sig_w;
  logic signed [8:0] sh_w;
  logic [31:0]       sh_mag;
  logic              sh_rnd;

  assign exp_w = f_q[30:23];
  assign sig_w = {1'b1, f_q[22:0]};
  assign sh_w  = $signed({1'b0, exp_w}) - $signed(9'(SHB));

  i_norm_barrel_shift u_shift (
    .sig       (sig_w),
    .shift     (sh_w),
    .mag       (sh_mag),
    .round_bit (sh_rnd)
  );

`ifndef ROUND_NEAREST_EN
  logic unused_round;
  assign unused_round = sh_rnd;
`endif

  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    f_d      = f_q;
    mag_d    = mag_q;
    val_d    = val_q;
    result_d = result_q;
    ack_d    = ack_q;
    case (state_q)
      IDLE: if (Begin_FSM_FF) state_d = LOAD;
      LOAD: begin
        f_d     = F;
        state_d = ALIGN;
      end
      ALIGN: begin
        if (exp_w == 8'd0)                 cls_d = CLS_ZERO;
        else if (exp_w == 8'hFF)           cls_d = CLS_SAT;
        else if (exp_w >= EXP_SAT)         cls_d = CLS_SAT;
        else if (exp_w <= EXP_ZERO_LIMIT)  cls_d = CLS_ZERO;
        else                               cls_d = CLS_NORM;
        state_d = SHIFT;
      end
      SHIFT: begin
`ifdef ROUND_NEAREST_EN
        mag_d = sh_mag + {{(P-1){1'b0}}, sh_rnd};
`else
        mag_d = sh_mag;
`endif
        state_d = SIGN;
      end
      SIGN: begin
        case (cls_q)
          CLS_SAT:  val_d = f_q[P-1] ? NEG_SAT : POS_SAT;
          CLS_ZERO: val_d = '0;
          default:  val_d = f_q[P-1] ? -mag_q : mag_q;
        endcase
        state_d = DONE;
      end
      DONE: begin
        result_d = val_q;
        ack_d    = 1'b1;
        if (Begin_FSM_FF) begin
          ack_d   = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_FF) begin
    if (!RST_FF) begin
      state_q  <= IDLE;
      cls_q    <= CLS_NORM;
      f_q      <= '0;
      mag_q    <= '0;
      val_q    <= '0;
      result_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cls_q    <= cls_d;
      f_q      <= f_d;
      mag_q    <= mag_d;
      val_q    <= val_d;
      result_q <= result_d;
      ack_q    <= ack_d;
    end
  end

  assign ACK_FF = ack_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_i_norm_float_to_fixed.sv
// tb/tb_i_norm_float_to_fixed.sv - randomized self-checking bench against a real-arithmetic model
module tb_i_norm_float_to_fixed;

  logic        CLK = 1'b0;
  logic        RST_FF = 1'b0;
  logic        Begin_FSM_FF = 1'b0;
  logic [31:0] F = 32'd0;
  wire         ACK_FF;
  wire  [31:0] RESULT;

  int n_checks = 0;
  int n_errors = 0;

  i_norm_float_to_fixed dut (
    .CLK          (CLK),
    .RST_FF       (RST_FF),
    .Begin_FSM_FF (Begin_FSM_FF),
    .F            (F),
    .ACK_FF       (ACK_FF),
    .RESULT       (RESULT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Value of the float scaled by 2^26, truncated (or rounded half-up) on magnitude.
  function automatic logic [31:0] model(input logic [31:0] f);
    int     e;
    int     scale;
    real    v;
    longint mag;
    e = int'(f[30:23]);
    if (e == 0) return 32'd0;
    if (e == 255 || e >= 132) return f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    if (e <= 100) return 32'd0;
    v = real'({1'b1, f[22:0]});
    scale = e - 124;
    if (scale >= 0) repeat (scale) v = v * 2.0;
    else repeat (-scale) v = v / 2.0;
`ifdef ROUND_NEAREST_EN
    mag = longint'($rtoi(v + 0.5));
`else
    mag = longint'($rtoi(v));
`endif
    return f[31] ? 32'(-mag) : 32'(mag);
  endfunction

  task automatic convert(input logic [31:0] f, input logic [31:0] exp_v, input string tag,
                         input bit busy, input bit scramble);
    @(negedge CLK);
    F = f;
    Begin_FSM_FF = 1'b1;
    @(posedge CLK);
    #1;
    Begin_FSM_FF = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge CLK);
      #1;
      if (i == 1) begin
        if (scramble) F = $urandom;
        if (busy) Begin_FSM_FF = 1'b1;
      end
      if (i == 4) begin
        Begin_FSM_FF = 1'b0;
        check({tag, " ack_early"}, {31'd0, ACK_FF}, 32'd0);
      end
    end
    check({tag, " ack"}, {31'd0, ACK_FF}, 32'd1);
    check({tag, " result"}, RESULT, exp_v);
  endtask

  initial begin
    logic [31:0] f;
    logic [7:0]  e;
    repeat (2) @(posedge CLK);
    #1;
    check("reset ack", {31'd0, ACK_FF}, 32'd0);
    check("reset result", RESULT, 32'd0);
    @(negedge CLK);
    RST_FF = 1'b1;

    convert(32'h3F80_0000, 32'h0400_0000, "one", 1'b0, 1'b0);
    convert(32'hBF80_0000, 32'hFC00_0000, "neg_one", 1'b0, 1'b0);
    convert(32'h4174_0000, 32'h3D00_0000, "p15_25", 1'b1, 1'b0);
    convert(32'hC174_0000, 32'hC300_0000, "n15_25", 1'b0, 1'b1);
    convert(32'h3F93_3333, 32'h0499_9998, "p1_15", 1'b0, 1'b0);
`ifdef ROUND_NEAREST_EN
    convert(32'h3CCC_CCCD, 32'h0019_999A, "p0_025", 1'b0, 1'b0);
`else
    convert(32'h3CCC_CCCD, 32'h0019_9999, "p0_025", 1'b0, 1'b0);
`endif
    convert(32'h4200_0000, 32'h7FFF_FFFF, "p32_sat", 1'b0, 1'b0);
    convert(32'hC200_0000, 32'h8000_0000, "n32_sat", 1'b1, 1'b1);
    convert(32'h7F80_0000, 32'h7FFF_FFFF, "inf_sat", 1'b0, 1'b0);
    convert(32'h0000_0000, 32'h0000_0000, "zero", 1'b0, 1'b0);
    convert(32'h8000_0001, 32'h0000_0000, "neg_denorm", 1'b0, 1'b0);
    convert(32'h3200_0000, 32'h0000_0000, "exp100", 1'b0, 1'b0);
    convert(32'h41FF_FFFF, 32'h7FFF_FF80, "max_in_range", 1'b1, 1'b1);

    // Asynchronous reset while the converter sits in SHIFT.
    @(negedge CLK);
    F = 32'h4174_0000;
    Begin_FSM_FF = 1'b1;
    @(posedge CLK);
    #1;
    Begin_FSM_FF = 1'b0;
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    #1;
    RST_FF = 1'b0;
    #1;
    check("midreset ack", {31'd0, ACK_FF}, 32'd0);
    check("midreset result", RESULT, 32'd0);
    @(negedge CLK);
    RST_FF = 1'b1;
    convert(32'hBF93_3333, model(32'hBF93_3333), "after_reset", 1'b0, 1'b0);

    // Asynchronous reset while holding a result in DONE.
    #1;
    RST_FF = 1'b0;
    #1;
    check("done_reset ack", {31'd0, ACK_FF}, 32'd0);
    check("done_reset result", RESULT, 32'd0);
    @(negedge CLK);
    RST_FF = 1'b1;

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        f = $urandom;
      end else begin
        e = 8'($urandom_range(96, 136));
        f = {1'($urandom_range(0, 1)), e, 23'($urandom)};
      end
      convert(f, model(f), $sformatf("rand%0d_%08h", n, f),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i_norm_float_to_fixed.md
Name: i_norm_float_to_fixed

Overview:
- Converts one IEEE-754 single-precision operand F to a signed 32-bit two's-complement fixed-point value, format Q5.26 (1 sign bit, 5 integer bits, 26 fraction bits).
- Front-end normalisation stage of the natural-logarithm datapath.
- Start/acknowledge FSM: one conversion per Begin_FSM_FF pulse.

Parameters:
- P, 32, input float width and RESULT width (only 32 supported).
- FRAC, 26, number of fraction bits in RESULT.

Ports:
- CLK  input  1  system clock, rising edge.
- RST_FF  input  1  asynchronous active-low reset.
- Begin_FSM_FF  input  1  start request, sampled in IDLE.
- F  input  32  IEEE-754 single operand: sign F[31], exponent F[30:23], mantissa F[22:0].
- ACK_FF  output  1  result valid / conversion done.
- RESULT  output  32  Q5.26 two's-complement result.

Behaviour:
- Reset (RST_FF=0, asynchronous): state=IDLE, ACK_FF=0, RESULT=0, all internal registers cleared. Reset mid-conversion aborts immediately; no partial result is ever presented.
- States and transitions:
  - IDLE: Begin_FSM_FF=1 -> LOAD.
  - LOAD: register F. Compute sig={1,F[22:0]} (24 bits) and sh=exp-124 (signed) -> ALIGN.
  - ALIGN: classify the operand -> SHIFT.
  - SHIFT: magnitude = sh>=0 ? sig<<sh : sig>>(-sh). The right shift truncates toward zero -> SIGN.
  - SIGN: if F[31]=1, magnitude is two's-complemented -> DONE.
  - DONE: RESULT registered, ACK_FF=1. Stays in DONE until Begin_FSM_FF=1, which clears ACK_FF and goes to LOAD.
- Latency: Begin_FSM_FF sampled high at edge k gives ACK_FF=1 and valid RESULT after edge k+5.
- RESULT holds its value from DONE until the next conversion reaches DONE.
- ACK_FF is a level, not a pulse.
- Begin_FSM_FF in LOAD/ALIGN/SHIFT/SIGN is ignored.
- F is sampled only in LOAD; later changes to F do not affect the result in progress.
- Classification in ALIGN, in priority order:
  - exp=0 (zero/denormal): RESULT=0, regardless of sign.
  - exp=255 (Inf/NaN): saturate.
  - exp>=132 (|value|>=32): saturate.
  - right-shift amount >=24 (exp<=100): RESULT=0.
- Saturation values: positive gives 0x7FFFFFFF; negative gives 0x80000000.
- Largest in-range value: exp=131 with sig=0xFFFFFF gives 0x7FFFFF80 (no overflow).
- Negative result equals exact two's complement of the truncated magnitude (truncation toward zero).

Optional Feature:
- Macro ROUND_NEAREST_EN.
- Defined: the right shift rounds half-up on magnitude (adds bit sh_amt-1 of sig before shifting), then the sign is applied.
  - Example: 0.025 (0x3CCCCCCD) gives 0x0019999A.
  - Saturation and zero rules unchanged.
- Undefined: truncation toward zero.
  - Example: 0.025 gives 0x00199999.
- Latency is identical in both builds.

Decomposition:
- Shared package i_norm_pkg:
  - state enum (IDLE, LOAD, ALIGN, SHIFT, SIGN, DONE);
  - constants EXP_BIAS=127, FRAC=26, SHIFT_BIAS=124, EXP_SAT=132, EXP_ZERO_LIMIT=100, POS_SAT=32'h7FFFFFFF, NEG_SAT=32'h80000000.
- One sub-module: i_norm_barrel_shift. Inputs: 24-bit sig and signed shift. Output: 32-bit magnitude plus round bit. Purely combinational.
- The FSM and sign/saturation logic stay in the top module.

Test Plan:
- Reset release, then F=0x3F800000 (1.0) with a one-cycle Begin pulse -> ACK_FF=1 five edges later, RESULT=0x04000000.
- F=0xBF800000 (-1.0) -> 0xFC000000.
- F=0x41740000 (15.25) -> 0x3D000000; F=0xC1740000 (-15.25) -> 0xC3000000.
- F=0x3F933333 (1.15) -> 0x04999998; F=0x3CCCCCCD (0.025) -> 0x00199999 (0x0019999A with ROUND_NEAREST_EN).
- Boundaries:
  - F=0x42000000 (32.0) -> 0x7FFFFFFF; F=0xC2000000 -> 0x80000000.
  - F=0x7F800000 (Inf) -> 0x7FFFFFFF.
  - F=0x00000000 and F=0x80000001 -> 0.
  - F=0x32000000 (exp=100) -> 0.
- Protocol:
  - Begin pulses during busy states are ignored; latency stays 5.
  - Assert RST_FF=0 during SHIFT -> ACK_FF and RESULT clear asynchronously.
  - After release, a new conversion completes correctly.
  - Changing F after LOAD does not alter the result.
